// File: rtl/wb_stage.sv
// Writeback stage: commits ALU results directly and formats load data from the
// data RAM (byte/half/word, LWL/LWR merges), with a bounded wait for load data.
module wb_stage #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_we_i,
    input  logic [4:0]  in_waddr_i,
    input  logic [31:0] in_wdata_i,
    input  logic        in_load_i,
    input  logic [2:0]  in_ldop_i,
    input  logic [1:0]  in_addr_lo_i,
    input  logic [31:0] in_rt_i,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        load_err_o
);

    localparam logic [7:0] LastCyc = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StWait, StWrite} state_e;

    state_e      state_q;
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [2:0]  ldop_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] rt_q;
    logic [7:0]  cnt_q;
    logic        accept;
    logic        timeout;

    function automatic logic [31:0] fmt_load(input logic [2:0]  op,
                                             input logic [1:0]  alo,
                                             input logic [31:0] mem,
                                             input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = mem[{alo, 3'b000} +: 8];
        h = mem[{alo[1], 4'b0000} +: 16];
        case (op)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {24'h0, b};
            3'b010:  r = {{16{h[15]}}, h};
            3'b011:  r = {16'h0, h};
            3'b101: begin
                case (alo)
                    2'd0:    r = {mem[7:0], rt[23:0]};
                    2'd1:    r = {mem[15:0], rt[15:0]};
                    2'd2:    r = {mem[23:0], rt[7:0]};
                    default: r = mem;
                endcase
            end
            3'b110: begin
                case (alo)
                    2'd0:    r = mem;
                    2'd1:    r = {rt[31:24], mem[31:8]};
                    2'd2:    r = {rt[31:16], mem[31:16]};
                    default: r = {rt[31:8], mem[31:24]};
                endcase
            end
            default: r = mem;
        endcase
        return r;
    endfunction

    // in_ready drops combinationally with reset so nothing is accepted while held.
    assign in_ready_o  = rst_ni & (state_q != StWait);
    assign accept      = in_valid_i & in_ready_o & ~flush_i;
    assign timeout     = (state_q == StWait) & ~flush_i & ~ram_rvalid_i & (cnt_q == LastCyc);
    assign we_o        = (state_q == StWrite) & we_q & (waddr_q != 5'd0);
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign stall_req_o = (state_q == StWait);
    assign load_err_o  = timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            ldop_q    <= 3'd0;
            addr_lo_q <= 2'd0;
            rt_q      <= 32'd0;
            cnt_q     <= 8'd0;
        end else begin
            case (state_q)
                StIdle, StWrite: begin
                    if (accept) begin
                        waddr_q <= in_waddr_i;
                        we_q    <= in_we_i;
                        if (in_load_i) begin
                            ldop_q    <= in_ldop_i;
                            addr_lo_q <= in_addr_lo_i;
                            rt_q      <= in_rt_i;
                            cnt_q     <= 8'd0;
                            state_q   <= StWait;
                        end else begin
                            wdata_q <= in_wdata_i;
                            state_q <= StWrite;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    // Flush beats a same-cycle response; data beats a same-cycle timeout.
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (ram_rvalid_i) begin
                        wdata_q <= fmt_load(ldop_q, addr_lo_q, ram_rdata_i, rt_q);
                        state_q <= StWrite;
                    end else if (cnt_q == LastCyc) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed literal cases plus randomized traffic checked every
// cycle against a transaction-level model of pending load / pending write.
module tb_wb_stage;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_we = 1'b0;
    logic        in_load = 1'b0;
    logic        rvalid = 1'b0;
    logic [4:0]  in_waddr = '0;
    logic [31:0] in_wdata = '0;
    logic [31:0] in_rt = '0;
    logic [31:0] rdata = '0;
    logic [2:0]  ldop = '0;
    logic [1:0]  alo = '0;

    logic        in_ready, we, stall_req, load_err;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int errors = 0;
    int checks = 0;

    // Model: an outstanding load (with its wait count) and a write due this cycle.
    bit          m_pend = 0;
    int          m_wcnt = 0;
    bit          m_wr = 0;
    bit          m_we = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_op = 0;
    int          m_alo = 0;
    logic [31:0] m_rt = '0;

    wb_stage #(.TIMEOUT_CYC(T)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_we_i      (in_we),
        .in_waddr_i   (in_waddr),
        .in_wdata_i   (in_wdata),
        .in_load_i    (in_load),
        .in_ldop_i    (ldop),
        .in_addr_lo_i (alo),
        .in_rt_i      (in_rt),
        .ram_rvalid_i (rvalid),
        .ram_rdata_i  (rdata),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .stall_req_o  (stall_req),
        .load_err_o   (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fmt(input int op, input int a,
                                            input logic [31:0] mem, input logic [31:0] rt);
        logic [31:0] b, h;
        logic [63:0] mask;
        b = (mem >> (8 * a)) & 32'hFF;
        h = (mem >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            1: return b;
            2: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3: return h;
            5: begin
                mask = (64'd1 << (8 * (3 - a))) - 64'd1;
                return (mem << (8 * (3 - a))) | (rt & mask[31:0]);
            end
            6: return (mem >> (8 * a)) | (rt & ~(32'hFFFF_FFFF >> (8 * a)));
            default: return mem;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp();
        #1;
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_we", we, 0);
            chk("rst_stall", stall_req, 0);
            chk("rst_load_err", load_err, 0);
            chk("rst_waddr", waddr, 0);
            chk("rst_wdata", wdata, 0);
        end else begin
            chk("in_ready", in_ready, !m_pend);
            chk("stall_req", stall_req, m_pend);
            chk("load_err", load_err, m_pend && m_wcnt == T - 1 && !rvalid && !flush);
            chk("we", we, m_wr && m_we && m_addr != 0);
            if (m_wr) begin
                chk("waddr", waddr, m_addr);
                chk("wdata", wdata, m_data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_pend = 0;
            m_wr = 0;
        end else if (m_pend) begin
            m_wr = 0;
            if (flush) m_pend = 0;
            else if (rvalid) begin
                m_pend = 0;
                m_wr = 1;
                m_data = ref_fmt(m_op, m_alo, rdata, m_rt);
            end else if (m_wcnt == T - 1) m_pend = 0;
            else m_wcnt++;
        end else if (in_valid && !flush) begin
            m_addr = in_waddr;
            m_we = in_we;
            if (in_load) begin
                m_pend = 1;
                m_wcnt = 0;
                m_wr = 0;
                m_op = int'(ldop);
                m_alo = int'(alo);
                m_rt = in_rt;
            end else begin
                m_wr = 1;
                m_data = in_wdata;
            end
        end else begin
            m_wr = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0;
        flush = 0;
        rvalid = 0;
        in_load = 0;
    endtask

    task automatic present(input bit load, input logic [2:0] op, input logic [1:0] a,
                           input logic [31:0] rt, input logic [4:0] wa, input logic [31:0] wd);
        in_valid = 1;
        in_we = 1;
        in_load = load;
        ldop = op;
        alo = a;
        in_rt = rt;
        in_waddr = wa;
        in_wdata = wd;
    endtask

    task automatic load_seq(input string nm, input logic [2:0] op, input logic [1:0] a,
                            input logic [31:0] rt, input logic [4:0] wa, input int waits,
                            input logic [31:0] mem, input logic [31:0] exp);
        idle();
        present(1, op, a, rt, wa, 32'h0);
        cmp();
        tick();
        idle();
        for (int i = 0; i < waits; i++) begin
            rvalid = (i == waits - 1);
            rdata = mem;
            cmp();
            chk({nm, "_stall"}, stall_req, 1);
            tick();
        end
        idle();
        cmp();
        chk({nm, "_wdata"}, wdata, exp);
        chk({nm, "_we"}, we, 1);
        chk({nm, "_nostall"}, stall_req, 0);
        tick();
    endtask

    initial begin
        #2;
        cmp();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_we", we, 0);
        @(negedge clk);
        rst_n = 1;
        idle();
        cmp();
        chk("post_reset_ready", in_ready, 1);
        tick();

        // Non-load write, visible exactly one cycle later
        present(0, 3'd0, 2'd0, 32'h0, 5'd5, 32'hDEAD_BEEF);
        cmp();
        tick();
        idle();
        cmp();
        chk("alu_we", we, 1);
        chk("alu_waddr", waddr, 5);
        chk("alu_wdata", wdata, 32'hDEAD_BEEF);
        tick();
        cmp();
        chk("alu_we_once", we, 0);
        tick();

        load_seq("lb", 3'b000, 2'd2, 32'h0, 5'd7, 3, 32'h1280_3456, 32'hFFFF_FF80);
        load_seq("lwr", 3'b110, 2'd1, 32'hAABB_CCDD, 5'd8, 2, 32'h1122_3344, 32'hAA11_2233);
        load_seq("lwl", 3'b101, 2'd1, 32'hAABB_CCDD, 5'd9, 1, 32'h1122_3344, 32'h3344_CCDD);
        load_seq("lhu", 3'b011, 2'd3, 32'h0, 5'd10, 4, 32'h8765_4321, 32'h0000_8765);

        // Write to r0 is suppressed
        present(0, 3'd0, 2'd0, 32'h0, 5'd0, 32'h1234_5678);
        cmp();
        tick();
        idle();
        cmp();
        chk("r0_we", we, 0);
        tick();

        // Timeout: error on 4th wait cycle, then a late response is ignored
        present(1, 3'b100, 2'd0, 32'h0, 5'd11, 32'h0);
        cmp();
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            cmp();
            chk("to_load_err", load_err, i == 3);
            chk("to_stall", stall_req, 1);
            tick();
        end
        cmp();
        chk("to_idle_stall", stall_req, 0);
        chk("to_idle_ready", in_ready, 1);
        rvalid = 1;
        rdata = 32'hCAFE_F00D;
        tick();
        idle();
        cmp();
        chk("to_late_we", we, 0);
        tick();

        // Flush while waiting, then a stale response
        present(1, 3'b100, 2'd0, 32'h0, 5'd12, 32'h0);
        cmp();
        tick();
        idle();
        cmp();
        tick();
        flush = 1;
        cmp();
        tick();
        idle();
        rvalid = 1;
        cmp();
        chk("fl_stall", stall_req, 0);
        tick();
        idle();
        cmp();
        chk("fl_we", we, 0);
        tick();

        // Reset asserted mid-wait
        present(1, 3'b100, 2'd0, 32'h0, 5'd13, 32'h0);
        cmp();
        tick();
        idle();
        cmp();
        tick();
        #2;
        rst_n = 0;
        #1;
        chk("mr_stall", stall_req, 0);
        chk("mr_ready", in_ready, 0);
        chk("mr_waddr", waddr, 0);
        rvalid = 1;
        tick();
        rst_n = 1;
        cmp();
        chk("mr_post_ready", in_ready, 1);
        tick();
        idle();
        cmp();
        chk("mr_we", we, 0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 9) == 0);
            in_load = $urandom_range(0, 1);
            in_we = ($urandom_range(0, 7) != 0);
            in_waddr = 5'($urandom_range(0, 31));
            in_wdata = $urandom;
            ldop = 3'($urandom_range(0, 7));
            alo = 2'($urandom_range(0, 3));
            in_rt = $urandom;
            rvalid = ($urandom_range(0, 9) < 3);
            rdata = $urandom;
            cmp();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
